// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : State encodings and seven-segment helper for the alarm.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    localparam logic [2:0] ST_DISARMED  = 3'd0;
    localparam logic [2:0] ST_ARMED     = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN = 3'd2;
    localparam logic [2:0] ST_ALERT     = 3'd3;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_zone_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : alarm_zone_controller_if
// Description : UID reader handshake (strobe + UID) into the zone controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface alarm_zone_controller_if #(
    parameter int UID_W = 32
) ();

    logic             uid_valid;
    logic [UID_W-1:0] uid;

    modport master (output uid_valid, output uid);
    modport slave  (input  uid_valid, input  uid);

endinterface
`default_nettype wire

// File: rtl/sec_ticker.sv
`default_nettype none
// ============================================================================
// Module      : sec_ticker
// Description : One-cycle tick every TICK_DIV clocks while run is high.
// Revision    : 1.0 - initial release
// ============================================================================
module sec_ticker #(
    parameter int TICK_DIV = 50000000
) (
    input  wire logic CLOCK_50,
    input  wire logic reset,
    input  wire logic run,
    input  wire logic restart,
    output logic      tick
);

    localparam int               CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!run || restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = run & (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/alarm_zone_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_zone_controller
// Description : Zone-masked intruder alarm with entry countdown, UID
//               authentication and timed lockout after repeated bad tags.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_zone_controller
    import alarm_pkg::*;
#(
    parameter int                         NUM_ZONES    = 2,
    parameter int                         UID_W        = 32,
    parameter int                         NUM_UIDS     = 2,
    parameter logic [NUM_UIDS*UID_W-1:0]  AUTH_UIDS    = {32'h332C1EB7, 32'h336BF410},
    parameter int                         TICK_DIV     = 50000000,
    parameter int                         ENTRY_SECS   = 60,
    parameter int                         MAX_FAILS    = 3,
    parameter int                         LOCKOUT_SECS = 30
) (
    input  wire logic                 CLOCK_50,
    input  wire logic                 reset,
    input  wire logic                 engage,
    input  wire logic [NUM_ZONES-1:0] zone_motion,
    input  wire logic [NUM_ZONES-1:0] zone_mask,
    alarm_zone_controller_if.slave    uid_bus,
    output logic [2:0]                state,
    output logic                      engaged,
    output logic                      authenticated,
    output logic                      buzzer,
    output logic [7:0]                secs_left,
    output logic [NUM_ZONES-1:0]      tripped,
    output logic [3:0]                fail_count,
    output logic                      locked_out
);

    localparam logic [7:0] c_entry_secs = 8'(ENTRY_SECS);
    localparam logic [7:0] c_lock_secs  = 8'(LOCKOUT_SECS);
    localparam logic [3:0] c_max_fails  = 4'(MAX_FAILS);

    logic [NUM_ZONES-1:0] r_motion_meta, r_motion_sync, r_mask;
    logic [2:0]           r_state;
    logic                 r_auth, r_locked;
    logic [7:0]           r_secs;
    logic [NUM_ZONES-1:0] r_tripped;
    logic [3:0]           r_fail;

    logic [2:0]           w_state_nx;
    logic                 w_auth_nx, w_locked_nx;
    logic [7:0]           w_secs_nx;
    logic [NUM_ZONES-1:0] w_tripped_nx, w_mask_nx;
    logic [3:0]           w_fail_nx;
    logic                 w_disarm, w_fail_evt, w_restart, w_tick, w_run;

    logic [NUM_UIDS-1:0]  w_uid_eq;
    logic                 w_uid_ok, w_match, w_mismatch;
    logic [NUM_ZONES-1:0] w_hit_vec;
    logic                 w_hit;
    logic [3:0]           w_fail_inc;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_motion_meta <= '0;
            r_motion_sync <= '0;
        end else begin
            r_motion_meta <= zone_motion;
            r_motion_sync <= r_motion_meta;
        end
    end

    for (genvar gi = 0; gi < NUM_UIDS; gi++) begin : g_uid_cmp
        assign w_uid_eq[gi] = (uid_bus.uid == AUTH_UIDS[gi*UID_W +: UID_W]);
    end

    assign w_uid_ok   = |w_uid_eq;
    assign w_match    = uid_bus.uid_valid & w_uid_ok;
    assign w_mismatch = uid_bus.uid_valid & ~w_uid_ok;
    assign w_hit_vec  = r_motion_sync & r_mask;
    assign w_hit      = |w_hit_vec;
    assign w_fail_inc = (r_fail == 4'hF) ? 4'hF : r_fail + 4'd1;
    assign w_run      = (r_state == ST_COUNTDOWN) | r_locked;

    sec_ticker #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_ticker (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .run      (w_run),
        .restart  (w_restart),
        .tick     (w_tick)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_mask_nx    = r_mask;
        w_auth_nx    = r_auth;
        w_tripped_nx = r_tripped;
        w_fail_nx    = r_fail;
        w_secs_nx    = r_secs;
        w_locked_nx  = r_locked;
        w_disarm     = 1'b0;
        w_fail_evt   = 1'b0;
        w_restart    = 1'b0;

        case (r_state)
            ST_DISARMED: begin
                if (engage) begin
                    w_state_nx   = ST_ARMED;
                    w_mask_nx    = zone_mask;
                    w_auth_nx    = 1'b0;
                    w_tripped_nx = '0;
                    w_fail_nx    = '0;
                end else if (uid_bus.uid_valid) begin
                    w_auth_nx = w_uid_ok;
                end
            end
            ST_ARMED: begin
                if (w_match) begin
                    w_disarm = 1'b1;
                end else begin
                    if (w_hit) begin
                        w_state_nx   = ST_COUNTDOWN;
                        w_tripped_nx = r_tripped | w_hit_vec;
                        w_secs_nx    = c_entry_secs;
                    end
                    w_fail_evt = w_mismatch;
                end
            end
            ST_COUNTDOWN: begin
                w_tripped_nx = r_tripped | w_hit_vec;
                if (w_match) begin
                    w_disarm = 1'b1;
                end else begin
                    if (w_tick) begin
                        if (r_secs == 8'd1) begin
                            w_state_nx = ST_ALERT;
                            w_secs_nx  = 8'd0;
                        end else begin
                            w_secs_nx = r_secs - 8'd1;
                        end
                    end
                    w_fail_evt = w_mismatch;
                end
            end
            ST_ALERT: begin
                // Lockout keeps the reader deaf until the timer expires
                if (r_locked) begin
                    if (w_tick) begin
                        if (r_secs == 8'd1) begin
                            w_locked_nx = 1'b0;
                            w_fail_nx   = '0;
                            w_secs_nx   = 8'd0;
                        end else begin
                            w_secs_nx = r_secs - 8'd1;
                        end
                    end
                end else if (w_match) begin
                    w_disarm = 1'b1;
                end else begin
                    w_fail_evt = w_mismatch;
                end
            end
            default: w_disarm = 1'b1;
        endcase

        // Reaching the fail limit overrides any countdown progress this cycle
        if (w_fail_evt) begin
            w_auth_nx = 1'b0;
            w_fail_nx = w_fail_inc;
            if (w_fail_inc == c_max_fails) begin
                w_state_nx  = ST_ALERT;
                w_locked_nx = 1'b1;
                w_secs_nx   = c_lock_secs;
                w_restart   = 1'b1;
            end
        end

        if (w_disarm) begin
            w_state_nx  = ST_DISARMED;
            w_auth_nx   = 1'b1;
            w_fail_nx   = '0;
            w_secs_nx   = 8'd0;
            w_locked_nx = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_DISARMED;
            r_mask    <= '0;
            r_auth    <= 1'b0;
            r_tripped <= '0;
            r_fail    <= '0;
            r_secs    <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_mask    <= w_mask_nx;
            r_auth    <= w_auth_nx;
            r_tripped <= w_tripped_nx;
            r_fail    <= w_fail_nx;
            r_secs    <= w_secs_nx;
            r_locked  <= w_locked_nx;
        end
    end

    assign state         = r_state;
    assign engaged       = (r_state == ST_ARMED) | (r_state == ST_COUNTDOWN) | (r_state == ST_ALERT);
    assign buzzer        = (r_state == ST_ALERT);
    assign authenticated = r_auth;
    assign secs_left     = r_secs;
    assign tripped       = r_tripped;
    assign fail_count    = r_fail;
    assign locked_out    = r_locked;

endmodule
`default_nettype wire
